// File: rtl/bus_slot_timer.sv
// bus_slot_timer: round-robin bus slot, bus clock and gated CPU clock generator; slot stretch enabled by BUS_SLOT_TIMER_STRETCH_EN
module bus_slot_timer #(
  parameter int NUM_SLOTS   = 8,
  parameter int CPU_SLOTS   = 2,
  parameter int SLOT_CYCLES = 2,
  parameter int STRETCH_MAX = 15,
  parameter int SLOT_W      = $clog2(NUM_SLOTS)
) (
  input  logic                 clk_16_i,
  input  logic                 reset_i,
  input  logic                 cpu_halt_i,
  input  logic                 stretch_i,
  output logic                 clk_bus_o,
  output logic [SLOT_W-1:0]    slot_o,
  output logic [NUM_SLOTS-1:0] slot_enable_o,
  output logic                 slot_start_o,
  output logic                 frame_start_o,
  output logic                 cpu_select_o,
  output logic                 cpu_enable_o,
  output logic                 clk_cpu_o
);
  localparam int PH_W = $clog2(SLOT_CYCLES);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(SLOT_CYCLES - 1);
  localparam logic [PH_W-1:0] PH_HALF = PH_W'(SLOT_CYCLES / 2);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_SLOTS - 1);
  localparam logic [SLOT_W-1:0] SLOT_CPU0 = SLOT_W'(NUM_SLOTS - CPU_SLOTS);
  logic [PH_W-1:0]   ph, ph_nxt;
  logic [SLOT_W-1:0] slot_nxt;
  logic              halt_latched, halt_nxt, hold, adv;
`ifdef BUS_SLOT_TIMER_STRETCH_EN
  localparam int CNT_W = $clog2(STRETCH_MAX + 1);
  logic [CNT_W-1:0] stretch_cnt;
  assign hold = stretch_i && ph == PH_LAST && stretch_cnt != CNT_W'(STRETCH_MAX);
  always_ff @(posedge clk_16_i) begin
    if (reset_i || adv) stretch_cnt <= '0;
    else if (hold) stretch_cnt <= stretch_cnt + CNT_W'(1);
  end
`else
  logic unused_stretch;
  assign unused_stretch = stretch_i;
  assign hold = 1'b0;
`endif
  // outputs are registered from next-state values so they track (ph, slot) with no lag
  always_comb begin
    adv      = !hold && ph == PH_LAST;
    ph_nxt   = adv ? '0 : hold ? ph : ph + PH_W'(1);
    slot_nxt = !adv ? slot_o : slot_o == SLOT_LAST ? '0 : slot_o + SLOT_W'(1);
    halt_nxt = (adv && slot_nxt == SLOT_LAST) ? cpu_halt_i : halt_latched;
  end
  always_ff @(posedge clk_16_i) begin
    if (reset_i) begin
      ph            <= '0;
      slot_o        <= '0;
      slot_enable_o <= NUM_SLOTS'(1);
      halt_latched  <= 1'b0;
      clk_bus_o     <= 1'b0;
      slot_start_o  <= 1'b1;
      frame_start_o <= 1'b1;
      cpu_select_o  <= 1'b0;
      cpu_enable_o  <= 1'b0;
      clk_cpu_o     <= 1'b0;
    end else begin
      ph            <= ph_nxt;
      slot_o        <= slot_nxt;
      slot_enable_o <= adv ? {slot_enable_o[NUM_SLOTS-2:0], slot_enable_o[NUM_SLOTS-1]} : slot_enable_o;
      halt_latched  <= halt_nxt;
      clk_bus_o     <= ph_nxt >= PH_HALF;
      slot_start_o  <= ph_nxt == '0;
      frame_start_o <= ph_nxt == '0 && slot_nxt == '0;
      cpu_select_o  <= slot_nxt >= SLOT_CPU0;
      cpu_enable_o  <= slot_nxt == SLOT_LAST;
      clk_cpu_o     <= ph_nxt >= PH_HALF && slot_nxt == SLOT_LAST && !halt_nxt;
    end
  end
endmodule

// File: tb/tb_bus_slot_timer.sv
// tb_bus_slot_timer: randomized check of bus_slot_timer against a slot/phase reference model
module tb_bus_slot_timer;
  localparam int N = 8, CS = 2, SC = 2, SMAX = 3;
  localparam int N2 = 5, SC2 = 4;
`ifdef BUS_SLOT_TIMER_STRETCH_EN
  localparam bit STR_EN = 1'b1;
`else
  localparam bit STR_EN = 1'b0;
`endif
  logic clk_16_i = 1'b0;
  always #5 clk_16_i = ~clk_16_i;
  logic reset_i = 1'b1, cpu_halt_i = 1'b0, stretch_i = 1'b0, no_stretch = 1'b0;
  logic clk_bus_o, slot_start_o, frame_start_o, cpu_select_o, cpu_enable_o, clk_cpu_o;
  logic [2:0] slot_o;
  logic [N-1:0] slot_enable_o;
  logic clk_bus_b, slot_start_b, frame_start_b, cpu_select_b, cpu_enable_b, clk_cpu_b;
  logic [2:0] slot_b;
  logic [N2-1:0] slot_enable_b;

  bus_slot_timer #(.NUM_SLOTS(N), .CPU_SLOTS(CS), .SLOT_CYCLES(SC), .STRETCH_MAX(SMAX)) u_dut (
    .clk_16_i(clk_16_i), .reset_i(reset_i), .cpu_halt_i(cpu_halt_i), .stretch_i(stretch_i),
    .clk_bus_o(clk_bus_o), .slot_o(slot_o), .slot_enable_o(slot_enable_o),
    .slot_start_o(slot_start_o), .frame_start_o(frame_start_o), .cpu_select_o(cpu_select_o),
    .cpu_enable_o(cpu_enable_o), .clk_cpu_o(clk_cpu_o));

  bus_slot_timer #(.NUM_SLOTS(N2), .CPU_SLOTS(1), .SLOT_CYCLES(SC2), .STRETCH_MAX(SMAX)) u_dut5 (
    .clk_16_i(clk_16_i), .reset_i(reset_i), .cpu_halt_i(cpu_halt_i), .stretch_i(no_stretch),
    .clk_bus_o(clk_bus_b), .slot_o(slot_b), .slot_enable_o(slot_enable_b),
    .slot_start_o(slot_start_b), .frame_start_o(frame_start_b), .cpu_select_o(cpu_select_b),
    .cpu_enable_o(cpu_enable_b), .clk_cpu_o(clk_cpu_b));

  int n_checks = 0, n_fail = 0;
  int m_slot = 0, m_ph = 0, m_cnt = 0, k2 = 0, pulses = 0;
  bit m_halt = 1'b0, prev_cpu = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit hold;
    if (reset_i) begin
      m_slot = 0; m_ph = 0; m_cnt = 0; m_halt = 1'b0; k2 = 0;
    end else begin
      k2++;
      hold = STR_EN && m_ph == SC - 1 && stretch_i && m_cnt < SMAX;
      if (hold) m_cnt++;
      else if (m_ph < SC - 1) m_ph++;
      else begin
        m_ph = 0;
        m_cnt = 0;
        m_slot = (m_slot + 1) % N;
        if (m_slot == N - 1) m_halt = cpu_halt_i;
      end
    end
  endtask

  task automatic compare_all();
    bit bus;
    int s2, p2;
    bus = m_ph >= SC / 2;
    check("slot", slot_o, m_slot);
    check("slot_enable", slot_enable_o, 64'(1) << m_slot);
    check("clk_bus", clk_bus_o, bus);
    check("slot_start", slot_start_o, m_ph == 0);
    check("frame_start", frame_start_o, m_ph == 0 && m_slot == 0);
    check("cpu_select", cpu_select_o, m_slot >= N - CS);
    check("cpu_enable", cpu_enable_o, m_slot == N - 1);
    check("clk_cpu", clk_cpu_o, bus && m_slot == N - 1 && !m_halt);
    s2 = (k2 / SC2) % N2;
    p2 = k2 % SC2;
    check("n5_slot", slot_b, s2);
    check("n5_slot_enable", slot_enable_b, 64'(1) << s2);
    check("n5_clk_bus", clk_bus_b, p2 >= SC2 / 2);
    check("n5_frame_start", frame_start_b, k2 % (SC2 * N2) == 0);
    if (frame_start_o) begin
      check("cpu_pulses_per_frame", pulses <= 1, 1);
      pulses = 0;
    end
    if (clk_cpu_o && !prev_cpu) pulses++;
    prev_cpu = clk_cpu_o;
  endtask

  task automatic cycle();
    @(posedge clk_16_i);
    model_step();
    @(negedge clk_16_i);
    compare_all();
  endtask

  task automatic wait_start(input int s);
    int i = 0;
    cycle();
    while (!(m_slot == s && m_ph == 0) && i < 200) begin
      cycle();
      i++;
    end
    if (i >= 200) check("wait_start_timeout", i, 0);
  endtask

  initial begin
    int pc, ec, len;
    @(negedge clk_16_i);
    repeat (3) cycle();
    check("reset_slot_start", slot_start_o, 1);
    reset_i = 1'b0;
    for (int i = 0; i < 48; i++) begin
      cycle();
      check("seq_slot", slot_o, (k2 / SC) % N);
    end
    // halt requested while entering the CPU slot, then dropped inside it
    wait_start(6);
    cpu_halt_i = 1'b1;
    wait_start(7);
    cpu_halt_i = 1'b0;
    pc = 0; ec = 0;
    for (int i = 0; i < SC; i++) begin
      pc += int'(clk_cpu_o); ec += int'(cpu_enable_o);
      cycle();
    end
    check("halt_cpu_cycles", pc, 0);
    check("halt_enable_cycles", ec, SC);
    wait_start(7);
    pc = 0; ec = 0;
    for (int i = 0; i < SC; i++) begin
      pc += int'(clk_cpu_o); ec += int'(cpu_enable_o);
      cycle();
    end
    check("nohalt_cpu_cycles", pc, SC / 2);
    check("nohalt_enable_cycles", ec, SC);
    // reset in the middle of the CPU pulse
    wait_start(7);
    cycle();
    check("pre_reset_clk_cpu", clk_cpu_o, 1);
    reset_i = 1'b1;
    cycle();
    reset_i = 1'b0;
    check("post_reset_slot", slot_o, 0);
    check("post_reset_clk_cpu", clk_cpu_o, 0);
    check("post_reset_frame", frame_start_o, 1);
    cycle();
    check("restart_ph1_slot", slot_o, 0);
    // stretch held for the whole slot, then a single-cycle stretch pulse
    wait_start(2);
    len = 1;
    stretch_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (slot_o != 3'd2) break;
      len++;
    end
    stretch_i = 1'b0;
    check("stretch_held_len", len, STR_EN ? SC + SMAX : SC);
    wait_start(2);
    len = 1;
    for (int i = 0; i < 40; i++) begin
      stretch_i = (len == 2);
      cycle();
      if (slot_o != 3'd2) break;
      len++;
    end
    stretch_i = 1'b0;
    check("stretch_pulse_len", len, STR_EN ? SC + 1 : SC);
    for (int i = 0; i < 10000; i++) begin
      cpu_halt_i = $urandom_range(0, 2) == 0;
      stretch_i  = $urandom_range(0, 3) == 0;
      reset_i    = $urandom_range(0, 1999) == 0;
      cycle();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
